// File: rtl/lif_spike_meter.sv
`default_nettype none
// ============================================================================
// Module      : lif_spike_meter
// Description : Spike rise counter over a programmable window of enabled
//               cycles (firing rate) plus inter-spike interval measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_spike_meter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_sat,
    output logic             rate_valid,
    output logic [WIN_W-1:0] isi_out,
    output logic             isi_valid
);

    logic             r_spike_d;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_spk_cnt;
    logic             r_sat_w;
    logic [WIN_W-1:0] r_isi_cnt;
    logic             r_have_prev;
    logic [CNT_W-1:0] r_rate_out;
    logic             r_rate_sat;
    logic             r_rate_valid;
    logic [WIN_W-1:0] r_isi_out;
    logic             r_isi_valid;

    logic             w_edge;
    logic             w_win_on;
    logic [WIN_W-1:0] w_win_last;
    logic             w_win_end;
    logic             w_spk_max;
    logic [CNT_W-1:0] w_spk_next;
    logic [WIN_W-1:0] w_isi_inc;

    assign w_edge     = spike_in & ~r_spike_d & en;
    assign w_win_on   = (win_len != '0);
    assign w_win_last = win_len - WIN_W'(1);
    // >= rather than == so that shrinking win_len mid-window still closes it
    assign w_win_end  = w_win_on && (r_win_cnt >= w_win_last);
    assign w_spk_max  = &r_spk_cnt;
    assign w_spk_next = (w_edge && !w_spk_max) ? r_spk_cnt + CNT_W'(1) : r_spk_cnt;
    assign w_isi_inc  = (&r_isi_cnt) ? r_isi_cnt : r_isi_cnt + WIN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_d <= 1'b0;
        end else begin
            r_spike_d <= spike_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_sat_w      <= 1'b0;
            r_isi_cnt    <= '0;
            r_have_prev  <= 1'b0;
            r_rate_out   <= '0;
            r_rate_sat   <= 1'b0;
            r_rate_valid <= 1'b0;
            r_isi_out    <= '0;
            r_isi_valid  <= 1'b0;
        end else if (clear) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_sat_w      <= 1'b0;
            r_isi_cnt    <= '0;
            r_have_prev  <= 1'b0;
            r_rate_out   <= '0;
            r_rate_sat   <= 1'b0;
            r_rate_valid <= 1'b0;
            r_isi_out    <= '0;
            r_isi_valid  <= 1'b0;
        end else if (!en) begin
            r_rate_valid <= 1'b0;
            r_isi_valid  <= 1'b0;
        end else begin
            r_rate_valid <= 1'b0;
            r_isi_valid  <= 1'b0;

            if (!w_win_on) begin
                r_win_cnt <= '0;
                r_spk_cnt <= '0;
                r_sat_w   <= 1'b0;
            end else if (w_win_end) begin
                // the closing cycle's edge belongs to the window being reported
                r_rate_out   <= w_spk_next;
                r_rate_sat   <= r_sat_w | (w_edge & w_spk_max);
                r_rate_valid <= 1'b1;
                r_win_cnt    <= '0;
                r_spk_cnt    <= '0;
                r_sat_w      <= 1'b0;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_spk_cnt <= w_spk_next;
                if (w_edge && w_spk_max) begin
                    r_sat_w <= 1'b1;
                end
            end

            if (w_edge) begin
                if (r_have_prev) begin
                    r_isi_out   <= w_isi_inc;
                    r_isi_valid <= 1'b1;
                end
                r_have_prev <= 1'b1;
                r_isi_cnt   <= '0;
            end else begin
                r_isi_cnt <= w_isi_inc;
            end
        end
    end

    assign rate_out   = r_rate_out;
    assign rate_sat   = r_rate_sat;
    assign rate_valid = r_rate_valid;
    assign isi_out    = r_isi_out;
    assign isi_valid  = r_isi_valid;

endmodule
`default_nettype wire

// File: tb/tb_lif_spike_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_spike_meter
// Description : Self-checking bench for lif_spike_meter against a timestamp
//               based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_spike_meter;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int C_CMAX = (1 << CNT_W) - 1;
    localparam int C_WMAX = (1 << WIN_W) - 1;
    localparam int VW = CNT_W + WIN_W + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             clear = 1'b0;
    logic             spike_in = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic [CNT_W-1:0] rate_out;
    logic             rate_sat;
    logic             rate_valid;
    logic [WIN_W-1:0] isi_out;
    logic             isi_valid;

    int checks = 0;
    int errors = 0;

    lif_spike_meter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .spike_in(spike_in),
        .win_len(win_len), .rate_out(rate_out), .rate_sat(rate_sat),
        .rate_valid(rate_valid), .isi_out(isi_out), .isi_valid(isi_valid)
    );

    always #5 clk = ~clk;

    wire [VW-1:0] dut_vec = {rate_out, rate_sat, rate_valid, isi_out, isi_valid};

    // Reference model: window tracked as an unsaturated spike tally, ISI as the
    // difference of enabled-cycle timestamps.
    bit               m_prev;
    int               m_t, m_pos, m_spk, m_last;
    bit               m_have;
    logic [CNT_W-1:0] m_rate;
    logic             m_rsat, m_rv, m_iv;
    logic [WIN_W-1:0] m_isi;

    function automatic logic [VW-1:0] exp_vec();
        return {m_rate, m_rsat, m_rv, m_isi, m_iv};
    endfunction

    task automatic model_reset();
        m_prev = 0; m_pos = 0; m_spk = 0; m_have = 0; m_last = 0;
        m_rate = '0; m_rsat = 0; m_rv = 0; m_isi = '0; m_iv = 0;
    endtask

    task automatic model_step();
        bit e;
        int tot, d;
        e = spike_in && !m_prev && en;
        m_prev = spike_in;
        if (clear) begin
            model_reset();
            m_prev = spike_in;
        end else if (!en) begin
            m_rv = 0; m_iv = 0;
        end else begin
            m_rv = 0; m_iv = 0; m_t++;
            if (win_len == 0) begin
                m_pos = 0; m_spk = 0;
            end else if (m_pos + 1 >= int'(win_len)) begin
                tot = m_spk + int'(e);
                m_rate = CNT_W'((tot > C_CMAX) ? C_CMAX : tot);
                m_rsat = (tot > C_CMAX);
                m_rv = 1; m_pos = 0; m_spk = 0;
            end else begin
                m_pos++;
                m_spk += int'(e);
            end
            if (e) begin
                if (m_have) begin
                    d = m_t - m_last;
                    m_isi = WIN_W'((d > C_WMAX) ? C_WMAX : d);
                    m_iv = 1;
                end
                m_have = 1;
                m_last = m_t;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_init: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b1; win_len = 16'd3;
        for (int i = 0; i < 12; i++) begin
            spike_in = (i % 3 == 0);
            tick();
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pre_async_reset: got %h expected %h", dut_vec, exp_vec());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        model_reset();
        spike_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        win_len = 16'd10; en = 1'b1; spike_in = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (rate_valid && rate_out !== 0)) begin
                errors++;
                $display("FAIL idle cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_rate();
        win_len = 16'd20; en = 1'b1; spike_in = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 80; i++) begin
            // last window: one spike held for three cycles
            spike_in = (i < 60) ? (i % 4 == 0) : (i >= 62 && i < 65);
            tick();
            checks++;
            if (dut_vec !== exp_vec() ||
                (rate_valid && i < 60 && (rate_out !== 8'd5 || rate_sat !== 1'b0)) ||
                (rate_valid && i >= 60 && rate_out !== 8'd1)) begin
                errors++;
                $display("FAIL rate cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_boundary();
        win_len = 16'd20; en = 1'b1; spike_in = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 40; i++) begin
            spike_in = (i == 19);
            tick();
            checks++;
            if (dut_vec !== exp_vec() ||
                (rate_valid && rate_out !== ((i == 19) ? 8'd1 : 8'd0))) begin
                errors++;
                $display("FAIL boundary cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        int seen;
        seen = 0;
        win_len = 16'd1000; en = 1'b1; spike_in = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            spike_in = (i < 1000) ? (i % 2 == 0) : (i == 1000 || i == 1010 || i == 1020);
            tick();
            if (rate_valid) seen++;
            checks++;
            if (dut_vec !== exp_vec() ||
                (rate_valid && i == 999 && {rate_out, rate_sat} !== {8'd255, 1'b1}) ||
                (rate_valid && i == 1999 && {rate_out, rate_sat} !== {8'd3, 1'b0})) begin
                errors++;
                $display("FAIL saturation cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (seen !== 2) begin
            errors++;
            $display("FAIL saturation_windows: got %0d expected %0d", seen, 2);
        end
    endtask

    task automatic test_isi();
        int n;
        logic [WIN_W-1:0] want [3];
        want[0] = 16'd7; want[1] = 16'd28; want[2] = 16'd15;
        n = 0;
        win_len = '0; en = 1'b1; spike_in = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 46; i++) begin
            spike_in = (i == 5 || i == 12 || i == 40);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (isi_valid && (n > 1 || isi_out !== want[n]))) begin
                errors++;
                $display("FAIL isi cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (isi_valid) n++;
        end
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 40; i++) begin
            en = !(i >= 8 && i < 18);
            spike_in = (i == 0 || i == 25);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (isi_valid && isi_out !== want[2])) begin
                errors++;
                $display("FAIL isi_gap cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (isi_valid) n++;
        end
        en = 1'b1;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL isi_count: got %0d expected %0d", n, 3);
        end
    endtask

    task automatic test_clear_en();
        win_len = 16'd50; en = 1'b1; spike_in = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            spike_in = (i == 3);
            tick();
        end
        clear = 1'b1; spike_in = 1'b1; tick(); clear = 1'b0; spike_in = 1'b0;
        checks++;
        if (dut_vec !== '0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clear_coincident: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        tick();
        spike_in = 1'b1; tick(); spike_in = 1'b0;
        checks++;
        if (isi_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL first_after_clear: got %h expected %h", dut_vec, exp_vec());
        end
        // a rise under en=0 is consumed by the edge detector and never counted
        en = 1'b0; spike_in = 1'b1; tick();
        en = 1'b1; tick(); tick(); spike_in = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (rate_valid && rate_out !== 8'd1)) begin
                errors++;
                $display("FAIL en_low_rise cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        win_len = 16'd10;
        tick();
        checks++;
        if (rate_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL shrink_close: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom % 8) != 0;
            clear = ($urandom % 300) == 0;
            if ($urandom % 4 == 0) spike_in = ~spike_in;
            if ($urandom % 150 == 0) win_len = WIN_W'($urandom_range(0, 30));
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        m_t = 0;
        model_reset();
        test_reset();
        test_idle();
        test_rate();
        test_boundary();
        test_saturation();
        test_isi();
        test_clear_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
